// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS payload LSB first, optional parity, 1-2 stop bits.
// Latency: tx drops one clock after the accepting edge, or two with UART_TX_FIFO_EN and an empty FIFO.
// Backpressure: in_ready only in IDLE or on the final stop clock; with UART_TX_FIFO_EN in_ready = !full.
// Optional macro UART_TX_FIFO_EN inserts a FIFO_DEPTH-entry burst FIFO between handshake and FSM.

`ifdef UART_TX_FIFO_EN
// Generic synchronous FIFO with a show-ahead read port (rd_dat is the current head).
// Latency: a written word is visible at rd_dat the cycle after the write edge.
// Backpressure: full blocks writes, empty blocks reads; simultaneous read/write keeps occupancy.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             wr_vld,
   output logic             full,
   input  logic             rd_rdy,
   output logic [WIDTH-1:0] rd_dat,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   assign full   = (count == CNT_FULL);
   assign empty  = (count == '0);
   assign do_wr  = wr_vld && !full;
   assign do_rd  = rd_rdy && !empty;
   assign rd_dat = mem[rd_ptr];

   // Storage array: plain write port, contents need no reset.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_dat;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end
endmodule
`endif

module uart_tx_param #(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int BAUD_RATE   = 9600,
   parameter int BAUD_DIV    = CLK_FREQ / BAUD_RATE,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);
   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic          ODD_PAR   = (PARITY_MODE == 2);

   // Illegal configurations stop elaboration rather than producing a silently wrong line.
   generate
      if (BAUD_DIV < 2) begin : g_chk_div
         $error("uart_tx_param: BAUD_DIV must be >= 2");
      end
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
         $error("uart_tx_param: DATA_BITS must be 5..9");
      end
      if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_chk_par
         $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
         $error("uart_tx_param: STOP_BITS must be 1 or 2");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fifo
         $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state, state_nxt;
   logic [BW-1:0]        baud_cnt, baud_nxt;
   logic [3:0]           bit_cnt, bit_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic                 par_bit, par_nxt;
   logic                 tx_nxt;
   logic                 bit_end;
   logic                 frame_end;
   logic                 load;
   logic [DATA_BITS-1:0] load_dat;

   assign bit_end   = (baud_cnt == BAUD_LAST);
   // Last clock of the last stop bit: the only point a new word may chain on.
   assign frame_end = (state == STOP) && (bit_cnt == STOP_LAST) && bit_end;
   assign tx_done   = frame_end;

`ifdef UART_TX_FIFO_EN
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_pop;
   logic [DATA_BITS-1:0] fifo_dat;

   assign fifo_pop = !fifo_empty && ((state == IDLE) || frame_end);

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_dat  (in_data),
      .wr_vld  (in_valid),
      .full    (fifo_full),
      .rd_rdy  (fifo_pop),
      .rd_dat  (fifo_dat),
      .empty   (fifo_empty)
   );

   assign in_ready = !fifo_full;
   assign load     = fifo_pop;
   assign load_dat = fifo_dat;
   assign tx_busy  = (state != IDLE) || !fifo_empty;
`else
   assign in_ready = (state == IDLE) || frame_end;
   assign load     = in_valid && in_ready;
   assign load_dat = in_data;
   assign tx_busy  = (state != IDLE);
`endif

   // Next-state, bit timing and shift logic; a load always restarts the frame at START.
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt + BW'(1);
      bit_nxt   = bit_cnt;
      shreg_nxt = shreg;
      par_nxt   = par_bit;
      case (state)
         IDLE: begin
            baud_nxt = '0;
            bit_nxt  = '0;
         end
         START: begin
            if (bit_end) begin
               state_nxt = DATA;
               baud_nxt  = '0;
               bit_nxt   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_nxt  = '0;
               shreg_nxt = shreg >> 1;
               if (bit_cnt == DATA_LAST) begin
                  bit_nxt   = '0;
                  state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
               end else begin
                  bit_nxt = bit_cnt + 4'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_nxt = STOP;
               baud_nxt  = '0;
               bit_nxt   = '0;
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_nxt = '0;
               if (bit_cnt == STOP_LAST) begin
                  state_nxt = IDLE;
                  bit_nxt   = '0;
               end else begin
                  bit_nxt = bit_cnt + 4'd1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            baud_nxt  = '0;
            bit_nxt   = '0;
         end
      endcase
      if (load) begin
         state_nxt = START;
         baud_nxt  = '0;
         bit_nxt   = '0;
         shreg_nxt = load_dat;
         par_nxt   = (^load_dat) ^ ODD_PAR;
      end
   end

   // Line level for the upcoming cycle, so tx itself comes straight from a flop.
   always_comb begin
      tx_nxt = 1'b1;
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shreg_nxt[0];
         PARITY:  tx_nxt = par_nxt;
         default: tx_nxt = 1'b1;
      endcase
   end

   // State and datapath registers; reset abandons any frame and releases the line.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         tx       <= 1'b1;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_cnt  <= bit_nxt;
         shreg    <= shreg_nxt;
         par_bit  <= par_nxt;
         tx       <= tx_nxt;
      end
   end
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three frame formats (8N1, 8E1 at /10, 7O2 at /5) run side by side.
// Each has a driver pushing expected words into a queue and a line monitor that pops one word
// per observed start bit and checks every clock of the frame against the ideal UART waveform.
module tb_uart_tx_param;
   localparam int NCFG   = 3;
   localparam int FDEPTH = 4;

   logic clk = 1'b0;
   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   n_done = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   for (genvar I = 0; I < NCFG; I++) begin : g_cfg
      localparam int DB   = (I == 2) ? 7 : 8;
      localparam int PM   = (I == 0) ? 0 : ((I == 1) ? 1 : 2);
      localparam int SB   = (I == 2) ? 2 : 1;
      localparam int BR   = (I == 2) ? 20_000_000 : 10_000_000;
      localparam int DIV  = 100_000_000 / BR;
      localparam int NB   = 1 + DB + ((PM != 0) ? 1 : 0) + SB;
      localparam int FL   = DIV * NB;
      localparam int MASK = (1 << DB) - 1;

      logic          reset_n  = 1'b0;
      logic [DB-1:0] in_data  = '0;
      logic          in_valid = 1'b0;
      logic          in_ready, tx, tx_busy, tx_done;

      int exp_q[$];
      int cyc     = 0;
      int pushed  = 0;
      int frames  = 0;
      int acc_cyc = 0;
      bit mon_act = 1'b0;

      uart_tx_param #(
         .CLK_FREQ    (100_000_000),
         .BAUD_RATE   (BR),
         .DATA_BITS   (DB),
         .PARITY_MODE (PM),
         .STOP_BITS   (SB),
         .FIFO_DEPTH  (FDEPTH)
      ) dut (
         .clk      (clk),
         .reset_n  (reset_n),
         .in_data  (in_data),
         .in_valid (in_valid),
         .in_ready (in_ready),
         .tx       (tx),
         .tx_busy  (tx_busy),
         .tx_done  (tx_done)
      );

      always @(posedge clk) cyc <= cyc + 1;

      // Ideal line level of bit slot k of a frame carrying word.
      function automatic int line_bit(input int word, input int k);
         int ones;
         ones = 0;
         if (k == 0) return 0;
         if (k <= DB) return (word >> (k - 1)) & 1;
         if (PM != 0 && k == DB + 1) begin
            for (int b = 0; b < DB; b++) ones += (word >> b) & 1;
            return (PM == 1) ? (ones % 2) : (1 - (ones % 2));
         end
         return 1;
      endfunction

      // Called at posedge+1; returns at posedge+1. Presents w for up to n cycles.
      task automatic attempt(input int w, input int n, output int acc);
         acc      = 0;
         in_valid = 1'b1;
         in_data  = DB'(w);
         for (int k = 0; k < n && acc == 0; k++) begin
            @(negedge clk);
            if (in_ready) begin
               acc     = 1;
               acc_cyc = cyc;
               exp_q.push_back(w & MASK);
               pushed++;
            end
            @(posedge clk); #1;
         end
         in_valid = 1'b0;
         in_data  = DB'($urandom);
      endtask

      task automatic send(input int w, output int acc);
         attempt(w, 6 * FL, acc);
         if (acc == 0) chk($sformatf("c%0d_send_timeout", I), 0, 1);
      endtask

      task automatic idle(input int n);
         repeat (n) begin
            @(posedge clk); #1;
         end
      endtask

      // Driver: directed scenarios, then randomized traffic, then drain.
      initial begin : drv
         int acc, n, a0, a1, w;
         int accs[6];
         repeat (3) @(posedge clk);
         @(negedge clk);
         chk($sformatf("c%0d_rst_tx", I),    int'(tx), 1);
         chk($sformatf("c%0d_rst_busy", I),  int'(tx_busy), 0);
         chk($sformatf("c%0d_rst_ready", I), int'(in_ready), 1);
         chk($sformatf("c%0d_rst_done", I),  int'(tx_done), 0);
         @(posedge clk); #1;
         reset_n = 1'b1;
         idle(2);

         // Single word from idle: tx_done lands on the last clock of the frame.
         send('hA5, acc);
         n = 0;
         for (int k = 0; k < 4 * FL; k++) begin
            @(negedge clk);
            n++;
            if (tx_done) break;
         end
`ifdef UART_TX_FIFO_EN
         chk($sformatf("c%0d_done_latency", I), n, FL + 1);
`else
         chk($sformatf("c%0d_done_latency", I), n, FL);
`endif
         idle(3);

         // Back-to-back: second accept only on the final stop clock.
         send($urandom, acc); a0 = acc_cyc;
         send($urandom, acc); a1 = acc_cyc;
`ifdef UART_TX_FIFO_EN
         chk($sformatf("c%0d_b2b_gap", I), a1 - a0, 1);
`else
         chk($sformatf("c%0d_b2b_gap", I), a1 - a0, FL);
`endif

         // One-cycle valid pulse in the middle of a frame.
         send($urandom, acc);
         idle(20);
         attempt($urandom, 1, acc);
`ifndef UART_TX_FIFO_EN
         chk($sformatf("c%0d_busy_reject", I), acc, 0);
`endif
         idle(3 * FL);

         // Reset low at clock 37 of a frame; the partial frame is abandoned.
         send($urandom, acc);
         repeat (36) @(posedge clk);
         #1 reset_n = 1'b0;
         @(negedge clk);
         @(negedge clk);
         chk($sformatf("c%0d_mrst_tx", I),    int'(tx), 1);
         chk($sformatf("c%0d_mrst_busy", I),  int'(tx_busy), 0);
         chk($sformatf("c%0d_mrst_ready", I), int'(in_ready), 1);
         chk($sformatf("c%0d_mrst_done", I),  int'(tx_done), 0);
         @(posedge clk); #1;
         reset_n = 1'b1;
         idle(2);

`ifdef UART_TX_FIFO_EN
         // Burst with valid held: one word enters the FSM, FDEPTH fill the FIFO, then stall.
         for (int j = 0; j < 6; j++) begin
            send($urandom, acc);
            accs[j] = acc_cyc;
         end
         chk($sformatf("c%0d_fifo_fill", I),  accs[4] - accs[0], FDEPTH);
         chk($sformatf("c%0d_fifo_stall", I), accs[5] - accs[0], FL + 2);
         idle(7 * FL);
`else
         accs[0] = 0;
`endif

         // Randomized traffic: random gaps, some offers withdrawn before transfer.
         for (int r = 0; r < 25; r++) begin
            in_data = DB'($urandom);
            idle($urandom_range(0, 12));
            w = $urandom;
            if ($urandom_range(0, 3) == 0) attempt(w, $urandom_range(1, 3), acc);
            else                           send(w, acc);
         end

         for (int k = 0; k < 10 * FL && (exp_q.size() != 0 || mon_act); k++) @(negedge clk);
         chk($sformatf("c%0d_drain", I),  exp_q.size(), 0);
         chk($sformatf("c%0d_frames", I), frames, pushed - 1);
         n_done++;
      end

      // Monitor: a falling line starts a frame; every clock is compared to the ideal waveform.
      initial begin : mon
         int  w, bad_tx, bad_done, bad_busy, bad_rdy;
         bit  ab, have;
         forever begin
            @(negedge clk);
            if (reset_n && tx === 1'b0) begin
               mon_act = 1'b1;
               have    = (exp_q.size() != 0);
               w       = 0;
               if (have) w = exp_q.pop_front();
               else      chk($sformatf("c%0d_unexpected_frame", I), 1, 0);
               bad_tx = 0; bad_done = 0; bad_busy = 0; bad_rdy = 0; ab = 1'b0;
               for (int c = 1; c <= FL; c++) begin
                  if (c > 1) @(negedge clk);
                  if (!reset_n) begin
                     ab = 1'b1;
                     break;
                  end
                  if (int'(tx) != line_bit(w, (c - 1) / DIV)) bad_tx++;
                  if (tx_done !== (c == FL)) bad_done++;
                  if (tx_busy !== 1'b1) bad_busy++;
`ifndef UART_TX_FIFO_EN
                  if (in_ready !== (c == FL)) bad_rdy++;
`endif
               end
               if (!ab && have) begin
                  chk($sformatf("c%0d_frame_bits_w%0h", I, w), bad_tx, 0);
                  chk($sformatf("c%0d_frame_done", I), bad_done, 0);
                  chk($sformatf("c%0d_frame_busy", I), bad_busy, 0);
                  chk($sformatf("c%0d_frame_ready", I), bad_rdy, 0);
                  frames++;
               end
               mon_act = 1'b0;
            end else if (reset_n) begin
               chk($sformatf("c%0d_idle_done", I), int'(tx_done), 0);
`ifndef UART_TX_FIFO_EN
               chk($sformatf("c%0d_idle_busy", I),  int'(tx_busy), 0);
               chk($sformatf("c%0d_idle_ready", I), int'(in_ready), 1);
`endif
            end
         end
      end
   end

   initial begin
      wait (n_done == NCFG);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #600_000;
      n_bad++;
      $display("FAIL watchdog: got no completion, expected all %0d drivers done", NCFG);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
